corr_window_sequencer: RTL and testbench
========================================

Name: corr_window_sequencer

Overview:
Window/timebase controller directly upstream of the logdrop correlation counter stage. It generates the sample strobe (the counter's clock gate), the in-window time index, the zero-counts pulse and a window-length exponent that is stable for the whole window. It also raises a valid/ack-handshaked "window complete" indication so a downstream reader knows when the four counts are final.

Parameters:
TIME_W, 8, width of the time index; maximum window length is 2**TIME_W samples.
PRESCALE_W, 16, width of the sample-period prescaler.
WINIDX_W, 16, width of the completed-window counter.

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset, asynchronous, active-low
i_enable  input  1  1 = run, 0 = stop and discard any partial window
i_prescaleMax  input  PRESCALE_W  clock cycles per sample, minus 1
i_windowLengthExp  input  $clog2(TIME_W+1)  requested log2 of the window length in samples
i_winAck  input  1  consumer has taken the completed window
i_clrOverrun  input  1  clears o_overrun
o_cg  output  1  one-cycle sample strobe; drives the counter's i_cg
o_t  output  TIME_W  sample index within the window, range 0..L-1
o_zeroCounts  output  1  high with o_cg on the first sample of each window
o_windowLengthExp  output  $clog2(TIME_W+1)  exponent latched for the current window
o_winValid  output  1  the completed window's counts are final
o_winIdx  output  WINIDX_W  number of completed windows, mod 2**WINIDX_W
o_overrun  output  1  sticky: a window completed while o_winValid was already high

Behaviour:
- All state uses an asynchronous active-low reset. Reset values: o_cg=0, o_t=0, o_zeroCounts=0, o_windowLengthExp=0, o_winValid=0, o_winIdx=0, o_overrun=0, prescaler=0.
- All outputs are registered.
- Prescaler:
  - While i_enable=1, the prescaler counts 0..i_prescaleMax and then wraps.
  - o_cg is high for exactly the one cycle after the prescaler wraps.
  - If i_enable is first sampled high on cycle N, the first o_cg is on cycle N+i_prescaleMax+1. The period is i_prescaleMax+1 cycles.
  - With i_prescaleMax=0, o_cg is high every cycle from N+1.
- Window length: L = 2**o_windowLengthExp.
  - o_windowLengthExp is loaded from i_windowLengthExp, clamped to TIME_W, on the prescaler wrap that precedes each window's first strobe.
  - It is constant for the remainder of the window. Changes mid-window take effect at the next window.
- Time index:
  - o_t advances only on cycles where o_cg=1. It presents the index of the current strobe.
  - On the strobe with o_t=L-1, the next strobe carries o_t=0.
  - When L=1 (exp 0), o_t stays 0 and every strobe is both the first and the last strobe of a window.
- o_zeroCounts = o_cg & (o_t==0).
- Completion:
  - The cycle after a strobe with o_t=L-1, the window is complete and o_winIdx increments (wraps).
  - If o_winValid=0, it rises that cycle.
  - If o_winValid=1 already, o_winValid stays 1 and o_overrun sets.
- Handshake:
  - o_winValid falls on the cycle after a cycle where o_winValid & i_winAck.
  - i_winAck while o_winValid=0 is ignored.
  - Completion and ack in the same cycle: a new completion wins, o_winValid stays 1 and no overrun is flagged.
- o_overrun clears on the cycle after i_clrOverrun=1. A simultaneous overrun event takes priority, so the flag stays set.
- i_enable=0: from the next cycle the prescaler=0, o_t=0 and o_cg=0. A partial window is discarded with no completion. o_winValid, o_overrun, o_winIdx and o_windowLengthExp hold.
- i_prescaleMax changed mid-count: if the prescaler is above the new max, it wraps at the next cycle.
- Reset asserted mid-window: all outputs take reset values immediately (asynchronously). No completion is reported.

Test Plan:
- Reset, enable=1, prescaleMax=0, exp=2 -> o_cg on every cycle; o_t = 0,1,2,3,0,1…; o_zeroCounts on strobes 1 and 5; o_winValid rises the cycle after the 4th strobe; o_winIdx=1.
- prescaleMax=3, exp=1 -> o_cg every 4th cycle, first at N+4; o_t alternates 0,1; o_winValid after strobe 2; i_winAck one cycle later -> o_winValid=0 the next cycle.
- exp 2->3 applied at strobe 2 of a window -> that window still completes after 4 strobes; the next window completes after 8 strobes; exp=9 with TIME_W=8 -> o_windowLengthExp=8 (256 strobes).
- No ack, exp=0, prescaleMax=0 -> o_winValid stays high, o_overrun=1 after the 2nd completion, o_winIdx counts 1,2,3…; i_clrOverrun pulse clears o_overrun (it re-sets if a completion coincides).
- i_enable dropped after strobe 2 of an exp=2 window -> o_cg and o_t return to 0, no completion; re-enable -> a full 4-strobe window starting with o_zeroCounts.
- i_rst_n pulsed low mid-window with o_winValid=1 -> all outputs 0 immediately; operation restarts cleanly after release.

Source files
------------

// File: rtl/corr_window_sequencer.sv
// Window/timebase controller for the logdrop correlation counters: sample strobe,
// in-window time index, zero-counts pulse, latched window exponent and completion handshake.
module corr_window_sequencer #(
  parameter int TIME_W     = 8,
  parameter int PRESCALE_W = 16,
  parameter int WINIDX_W   = 16,
  localparam int EXP_W     = $clog2(TIME_W + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [PRESCALE_W-1:0] i_prescaleMax,
  input  logic [EXP_W-1:0]      i_windowLengthExp,
  input  logic                  i_winAck,
  input  logic                  i_clrOverrun,
  output logic                  o_cg,
  output logic [TIME_W-1:0]     o_t,
  output logic                  o_zeroCounts,
  output logic [EXP_W-1:0]      o_windowLengthExp,
  output logic                  o_winValid,
  output logic [WINIDX_W-1:0]   o_winIdx,
  output logic                  o_overrun
);

  localparam int MASK_W = TIME_W + 1;

  logic [PRESCALE_W-1:0] prescale;
  logic [TIME_W-1:0]     t_next;    // index the next strobe will carry

  logic             wrap;
  logic [EXP_W-1:0] exp_clamped;
  logic [EXP_W-1:0] win_exp;
  logic             next_is_last;
  logic             complete;
  logic             set_overrun;

  function automatic logic [MASK_W-1:0] last_index(input logic [EXP_W-1:0] e);
    return (MASK_W'(1) << e) - MASK_W'(1);
  endfunction

  // NOTE: every signal gets a value on every path through always_comb, so no latches are inferred.
  always_comb begin
    // ">=" also covers a max lowered below the current count: wrap on the next cycle.
    wrap         = i_enable && (prescale >= i_prescaleMax);
    exp_clamped  = (i_windowLengthExp > EXP_W'(TIME_W)) ? EXP_W'(TIME_W) : i_windowLengthExp;
    win_exp      = (t_next == '0) ? exp_clamped : o_windowLengthExp;
    next_is_last = ({1'b0, t_next} == last_index(win_exp));
    complete     = o_cg && ({1'b0, o_t} == last_index(o_windowLengthExp));
    set_overrun  = complete && o_winValid && !i_winAck;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prescale          <= '0;
      t_next            <= '0;
      o_cg              <= 1'b0;
      o_t               <= '0;
      o_zeroCounts      <= 1'b0;
      o_windowLengthExp <= '0;
      o_winValid        <= 1'b0;
      o_winIdx          <= '0;
      o_overrun         <= 1'b0;
    end else begin
      if (!i_enable) begin
        prescale     <= '0;
        t_next       <= '0;
        o_cg         <= 1'b0;
        o_t          <= '0;
        o_zeroCounts <= 1'b0;
      end else if (wrap) begin
        prescale          <= '0;
        o_cg              <= 1'b1;
        o_t               <= t_next;
        o_zeroCounts      <= (t_next == '0);
        o_windowLengthExp <= win_exp;
        t_next            <= next_is_last ? '0 : t_next + 1'b1;
      end else begin
        prescale     <= prescale + 1'b1;
        o_cg         <= 1'b0;
        o_zeroCounts <= 1'b0;
      end

      // The strobe that closed a window already reached the counters, so completion is not gated by enable.
      if (complete) begin
        o_winValid <= 1'b1;
        o_winIdx   <= o_winIdx + 1'b1;
      end else if (o_winValid && i_winAck) begin
        o_winValid <= 1'b0;
      end

      if (set_overrun) begin
        o_overrun <= 1'b1;
      end else if (i_clrOverrun) begin
        o_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_corr_window_sequencer.sv
// Scoreboard bench for corr_window_sequencer: an arithmetic reference model queues expected
// strobes and completions; a negedge monitor pops and compares whatever the DUT presents.
module tb_corr_window_sequencer;

  localparam int TIME_W     = 8;
  localparam int PRESCALE_W = 16;
  localparam int WINIDX_W   = 16;
  localparam int EXP_W      = $clog2(TIME_W + 1);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  en;
  logic [PRESCALE_W-1:0] pmax;
  logic [EXP_W-1:0]      wexp;
  logic                  ack;
  logic                  clr;
  logic                  cg;
  logic [TIME_W-1:0]     t;
  logic                  zc;
  logic [EXP_W-1:0]      oexp;
  logic                  win_valid;
  logic [WINIDX_W-1:0]   win_idx;
  logic                  overrun;

  corr_window_sequencer #(
    .TIME_W(TIME_W), .PRESCALE_W(PRESCALE_W), .WINIDX_W(WINIDX_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_prescaleMax(pmax),
    .i_windowLengthExp(wexp), .i_winAck(ack), .i_clrOverrun(clr),
    .o_cg(cg), .o_t(t), .o_zeroCounts(zc), .o_windowLengthExp(oexp),
    .o_winValid(win_valid), .o_winIdx(win_idx), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  typedef struct { int cyc; int t; bit zc; int e; } strobe_t;
  typedef struct { int cyc; int idx; } comp_t;
  strobe_t sq[$];
  comp_t   cq[$];

  // Reference model: sample counter, position in window, window length as plain integers.
  int cyc = 0;
  int m_pre, m_next, m_exp, m_t, m_idx;
  bit m_cg, m_valid, m_ovr;
  bit mon_on = 1'b0;

  task automatic model_reset();
    m_pre = 0; m_next = 0; m_exp = 0; m_t = 0; m_idx = 0;
    m_cg = 0; m_valid = 0; m_ovr = 0;
    sq.delete(); cq.delete();
  endtask

  task automatic model_step();
    bit done;
    int len;
    cyc++;
    done = m_cg && (m_t == (1 << m_exp) - 1);
    if (done) begin
      if (m_valid && !ack) m_ovr = 1;
      else if (clr) m_ovr = 0;
      m_valid = 1;
      m_idx = (m_idx + 1) % (1 << WINIDX_W);
      cq.push_back('{cyc, m_idx});
    end else begin
      if (clr) m_ovr = 0;
      if (m_valid && ack) m_valid = 0;
    end
    if (!en) begin
      m_pre = 0; m_cg = 0; m_t = 0; m_next = 0;
    end else if (m_pre >= int'(pmax)) begin
      m_pre = 0; m_cg = 1;
      if (m_next == 0) m_exp = (int'(wexp) > TIME_W) ? TIME_W : int'(wexp);
      len = 1 << m_exp;
      m_t = m_next;
      m_next = (m_next + 1) % len;
      sq.push_back('{cyc, m_t, (m_t == 0), m_exp});
    end else begin
      m_pre++; m_cg = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cg"}, cg, 0);
    check({tag, "_t"}, t, 0);
    check({tag, "_zc"}, zc, 0);
    check({tag, "_exp"}, oexp, 0);
    check({tag, "_valid"}, win_valid, 0);
    check({tag, "_idx"}, win_idx, 0);
    check({tag, "_ovr"}, overrun, 0);
  endtask

  // Monitor: one expectation slot per cycle for strobes and for completions.
  int prev_idx = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_idx = 0;
    end else if (mon_on) begin
      automatic bit exp_cg = (sq.size() > 0) && (sq[0].cyc == cyc);
      automatic bit exp_cp = (cq.size() > 0) && (cq[0].cyc == cyc);
      automatic bit got_cp = (int'(win_idx) != prev_idx);
      check("cg", cg, exp_cg);
      if (exp_cg) begin
        automatic strobe_t s = sq.pop_front();
        if (cg) begin
          check("t", t, s.t);
          check("zero_counts", zc, s.zc);
          check("win_exp", oexp, s.e);
        end
      end else begin
        check("zero_counts_idle", zc, 0);
      end
      check("completion", got_cp, exp_cp);
      if (exp_cp) begin
        automatic comp_t c = cq.pop_front();
        if (got_cp) check("win_idx", win_idx, c.idx);
      end
      check("win_valid", win_valid, m_valid);
      check("overrun", overrun, m_ovr);
      prev_idx = int'(win_idx);
    end
  end

  initial begin
    rst_n = 1'b0; en = 0; pmax = '0; wexp = '0; ack = 0; clr = 0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_on = 1'b1;

    // Every-cycle strobes, 4-sample windows, then a late ack.
    en = 1; pmax = 0; wexp = 2;
    run(10);
    ack = 1; tick(); ack = 0;
    run(3);

    // Prescale 3, 2-sample windows, ack after completion.
    en = 0; tick();
    en = 1; pmax = 3; wexp = 1;
    run(12);
    ack = 1; tick(); ack = 0;
    run(10);

    // Exponent change mid-window takes effect at the next window.
    en = 0; tick();
    ack = 1; tick(); ack = 0;
    en = 1; pmax = 0; wexp = 2;
    run(2);
    wexp = 3;
    run(14);
    ack = 1; tick(); ack = 0;

    // Exponent 9 clamps to 8 (256-sample window).
    wexp = 9;
    run(270);
    check("exp_clamp", oexp, TIME_W);
    ack = 1; tick(); ack = 0;

    // Single-sample windows with no ack: overrun, then clear with and without coincident completion.
    en = 0; wexp = 0; tick();
    en = 1;
    run(6);
    en = 0; run(2);
    clr = 1; tick(); clr = 0;
    run(2);
    en = 1;
    run(3);
    clr = 1; tick(); clr = 0;
    run(3);
    ack = 1; tick(); ack = 0;

    // Disable after the 2nd strobe of a 4-sample window, then re-enable.
    en = 0; wexp = 2; tick();
    ack = 1; tick(); ack = 0;
    en = 1;
    run(2);
    en = 0; run(3);
    en = 1; run(6);

    // Asynchronous reset mid-window with a completed window pending.
    pmax = 1;
    run(5);
    rst_n = 1'b0;
    #2;
    check_all_zero("async_reset");
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    run(20);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if (i % 50 == 0) begin
        pmax = PRESCALE_W'($urandom_range(0, 3));
        wexp = EXP_W'($urandom_range(0, 9));
      end
      en  = ($urandom_range(0, 99) < 97);
      ack = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    en = 0; ack = 0; clr = 0;
    run(2);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
